mem_bank_sram_adapter: RTL and testbench



---
 rtl/mem_bank_sram_adapter.sv | 138 +++++++++++++
 tb/tb_mem_bank_sram_adapter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bank_sram_adapter.sv
// Per-bank adapter from a req/gnt/rvalid memory port to a fixed-latency single-port SRAM.
// Plain accesses stream at one per cycle; AtomicLoad-ADD runs as a blocking read-modify-write.
module mem_bank_sram_adapter #(
    parameter int AddrWidth     = 32,
    parameter int DataWidth     = 32,
    parameter int SramAddrWidth = 10,
    parameter int SramLatency   = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     mem_req_i,
    output logic                     mem_gnt_o,
    input  logic [AddrWidth-1:0]     mem_addr_i,
    input  logic [DataWidth-1:0]     mem_wdata_i,
    input  logic [DataWidth/8-1:0]   mem_strb_i,
    input  logic [5:0]               mem_atop_i,
    input  logic                     mem_we_i,
    output logic                     mem_rvalid_o,
    output logic [DataWidth-1:0]     mem_rdata_o,
    output logic                     sram_req_o,
    output logic                     sram_we_o,
    output logic [SramAddrWidth-1:0] sram_addr_o,
    output logic [DataWidth-1:0]     sram_wdata_o,
    output logic [DataWidth/8-1:0]   sram_be_o,
    input  logic [DataWidth-1:0]     sram_rdata_i,
    output logic                     busy_o
);

    localparam int StrbWidth = DataWidth / 8;
    localparam int ByteOff   = $clog2(StrbWidth);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RMW_WAIT  = 2'd1,
        RMW_WRITE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [SramLatency-1:0]   pipe_v, pipe_w, pipe_a;
    logic [SramLatency:0]     v_ext, w_ext, a_ext;
    logic [SramAddrWidth-1:0] word_addr, addr_q;
    logic [DataWidth-1:0]     operand_q, old_q;
    logic [StrbWidth-1:0]     strb_q;
    logic                     is_add, grant, out_v, out_w, out_a, atomic_out;
    logic                     unused_addr;

    assign unused_addr = ^mem_addr_i;
    assign word_addr   = mem_addr_i[ByteOff +: SramAddrWidth];
    assign is_add      = (mem_atop_i == 6'b100000) & mem_we_i;
    assign grant       = mem_req_i & mem_gnt_o & ~rst_i;

    // Tag pipeline: bit 0 is the tag pushed this cycle, oldest entry leaves at the top.
    assign v_ext = {pipe_v, grant};
    assign w_ext = {pipe_w, mem_we_i & ~is_add};
    assign a_ext = {pipe_a, is_add};

    assign out_v      = pipe_v[SramLatency-1];
    assign out_w      = pipe_w[SramLatency-1];
    assign out_a      = pipe_a[SramLatency-1];
    assign atomic_out = out_v & out_a;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (grant && is_add) state_d = RMW_WAIT;
            RMW_WAIT:  if (atomic_out) state_d = RMW_WRITE;
            RMW_WRITE: state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pipe_v <= '0;
            pipe_w <= '0;
            pipe_a <= '0;
        end else begin
            pipe_v <= v_ext[SramLatency-1:0];
            pipe_w <= w_ext[SramLatency-1:0];
            pipe_a <= a_ext[SramLatency-1:0];
        end
        if (grant && is_add) begin
            addr_q    <= word_addr;
            operand_q <= mem_wdata_i;
            strb_q    <= mem_strb_i;
        end
        // Old value is held so the response and the write-back share the RMW_WRITE cycle.
        if (state_q == RMW_WAIT && atomic_out) begin
            old_q <= sram_rdata_i;
        end
    end

    always_comb begin
        mem_gnt_o    = 1'b0;
        sram_req_o   = 1'b0;
        sram_we_o    = 1'b0;
        sram_addr_o  = addr_q;
        sram_wdata_o = '0;
        sram_be_o    = '0;
        mem_rvalid_o = out_v & ~out_a;
        mem_rdata_o  = out_w ? '0 : sram_rdata_i;
        case (state_q)
            IDLE: begin
                mem_gnt_o    = 1'b1;
                sram_req_o   = mem_req_i;
                sram_we_o    = mem_we_i & ~is_add;
                sram_addr_o  = word_addr;
                sram_wdata_o = mem_wdata_i;
                sram_be_o    = is_add ? '1 : mem_strb_i;
            end
            RMW_WRITE: begin
                sram_req_o   = 1'b1;
                sram_we_o    = 1'b1;
                sram_wdata_o = old_q + operand_q;
                sram_be_o    = strb_q;
                mem_rvalid_o = 1'b1;
                mem_rdata_o  = old_q;
            end
            default: ;
        endcase
        if (rst_i) begin
            sram_req_o   = 1'b0;
            mem_rvalid_o = 1'b0;
        end
    end

    assign busy_o = ~rst_i & ((|pipe_v) | (state_q != IDLE) | grant);

endmodule

// File: tb/tb_mem_bank_sram_adapter.sv
// Scoreboard bench for mem_bank_sram_adapter: a driver pushes expected responses,
// a negedge monitor pops and compares data and arrival cycle.
module tb_mem_bank_sram_adapter;

    localparam int LAT = 3;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int SAW = 10;
    localparam int SW  = DW / 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           mem_req = 1'b0;
    logic           mem_gnt_o;
    logic [AW-1:0]  mem_addr = '0;
    logic [DW-1:0]  mem_wdata = '0;
    logic [SW-1:0]  mem_strb = '0;
    logic [5:0]     mem_atop = '0;
    logic           mem_we = 1'b0;
    logic           mem_rvalid_o;
    logic [DW-1:0]  mem_rdata_o;
    logic           sram_req_o, sram_we_o;
    logic [SAW-1:0] sram_addr_o;
    logic [DW-1:0]  sram_wdata_o;
    logic [SW-1:0]  sram_be_o;
    logic [DW-1:0]  sram_rdata;
    logic           busy_o;

    mem_bank_sram_adapter #(
        .AddrWidth(AW), .DataWidth(DW), .SramAddrWidth(SAW), .SramLatency(LAT)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .mem_req_i(mem_req), .mem_gnt_o(mem_gnt_o), .mem_addr_i(mem_addr),
        .mem_wdata_i(mem_wdata), .mem_strb_i(mem_strb), .mem_atop_i(mem_atop),
        .mem_we_i(mem_we), .mem_rvalid_o(mem_rvalid_o), .mem_rdata_o(mem_rdata_o),
        .sram_req_o(sram_req_o), .sram_we_o(sram_we_o), .sram_addr_o(sram_addr_o),
        .sram_wdata_o(sram_wdata_o), .sram_be_o(sram_be_o), .sram_rdata_i(sram_rdata),
        .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // SRAM macro model with byte enables and LAT-cycle read latency.
    logic [DW-1:0] mem_model [0:1023];
    logic [DW-1:0] rd_pipe [LAT];
    always @(posedge clk) begin
        if (sram_req_o && sram_we_o)
            for (int b = 0; b < SW; b++)
                if (sram_be_o[b]) mem_model[sram_addr_o][8*b +: 8] <= sram_wdata_o[8*b +: 8];
        rd_pipe[0] <= (sram_req_o && !sram_we_o) ? mem_model[sram_addr_o] : 32'hBAD0_BAD0;
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign sram_rdata = rd_pipe[LAT-1];

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    int vectors = 0;
    int miscompares = 0;

    function automatic void check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    always @(negedge clk) begin
        if (!rst && mem_rvalid_o) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_rvalid: rdata %h at cycle %0d, none expected", mem_rdata_o, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check("rdata", mem_rdata_o, mon_e.data);
                check("rvalid_cycle", DW'(cyc), DW'(mon_e.cyc));
            end
        end
    end

    task automatic issue(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input logic [SW-1:0] strb, input logic [5:0] atop,
                         input logic [DW-1:0] exp_rdata, input int exp_wait);
        int   waits = 0;
        logic atomic;
        exp_t e;
        atomic    = we && (atop == 6'b100000);
        mem_req   = 1'b1;
        mem_we    = we;
        mem_addr  = addr;
        mem_wdata = wdata;
        mem_strb  = strb;
        mem_atop  = atop;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (mem_gnt_o) break;
            waits++;
        end
        if (!mem_gnt_o) begin
            vectors++;
            miscompares++;
            $display("FAIL grant_timeout: no grant for addr %h after %0d cycles", addr, waits);
        end else begin
            check("grant_wait", DW'(waits), DW'(exp_wait));
            check("sram_addr", DW'(sram_addr_o), DW'(addr[2 +: SAW]));
            check("busy_on_grant", DW'(busy_o), 32'd1);
            e.data = exp_rdata;
            e.cyc  = cyc + LAT + (atomic ? 1 : 0);
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_drain();
        mem_req = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        check("queue_drained", DW'(exp_q.size()), 32'd0);
        @(negedge clk);
        check("idle_sram_req", DW'(sram_req_o), 32'd0);
        check("idle_busy", DW'(busy_o), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with a pending request: no SRAM access, no response, not busy.
        rst     = 1'b1;
        mem_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rst_sram_req", DW'(sram_req_o), 32'd0);
            check("rst_rvalid", DW'(mem_rvalid_o), 32'd0);
            check("rst_busy", DW'(busy_o), 32'd0);
        end
        @(posedge clk);
        #1;
        rst     = 1'b0;
        mem_req = 1'b0;

        // Write then read at byte 0x10 (word 4); unaligned address resolves to the same word.
        issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 6'b0, 32'h0, 0);
        issue(1'b0, 32'h10, 32'h0, 4'hF, 6'b0, 32'hDEADBEEF, 0);
        issue(1'b0, 32'h13, 32'h0, 4'hF, 6'b0, 32'hDEADBEEF, 0);
        idle_drain();

        // Partial strobe keeps unselected bytes.
        issue(1'b1, 32'h20, 32'h11223344, 4'hF, 6'b0, 32'h0, 0);
        issue(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 6'b0, 32'h0, 0);
        issue(1'b0, 32'h20, 32'h0, 4'hF, 6'b0, 32'h11BB33DD, 0);
        idle_drain();

        // Atomic add with wrap-around, following read is held off LAT+1 cycles.
        issue(1'b1, 32'h0C, 32'hFFFFFFFE, 4'hF, 6'b0, 32'h0, 0);
        issue(1'b1, 32'h0C, 32'h00000003, 4'hF, 6'b100000, 32'hFFFFFFFE, 0);
        issue(1'b0, 32'h0C, 32'h0, 4'hF, 6'b0, 32'h00000001, LAT + 1);
        idle_drain();
        check("atomic_sram_word3", mem_model[3], 32'h00000001);

        // Ordering A, B, atomic C (partial strobe), D; then read C back.
        issue(1'b1, 32'h14, 32'hA0A0A0A0, 4'hF, 6'b0, 32'h0, 0);
        issue(1'b1, 32'h18, 32'hB0B0B0B0, 4'hF, 6'b0, 32'h0, 0);
        issue(1'b1, 32'h1C, 32'h12FF00FF, 4'hF, 6'b0, 32'h0, 0);
        issue(1'b1, 32'h24, 32'hD0D0D0D0, 4'hF, 6'b0, 32'h0, 0);
        issue(1'b0, 32'h14, 32'h0, 4'hF, 6'b0, 32'hA0A0A0A0, 0);
        issue(1'b0, 32'h18, 32'h0, 4'hF, 6'b0, 32'hB0B0B0B0, 0);
        issue(1'b1, 32'h1C, 32'h01010101, 4'b0011, 6'b100000, 32'h12FF00FF, 0);
        issue(1'b0, 32'h24, 32'h0, 4'hF, 6'b0, 32'hD0D0D0D0, LAT + 1);
        issue(1'b0, 32'h1C, 32'h0, 4'hF, 6'b0, 32'h12FF0200, 0);
        idle_drain();

        // Unsupported atop is a plain write; strobe-zero write still responds and changes nothing.
        issue(1'b1, 32'h28, 32'h00000055, 4'hF, 6'b110000, 32'h0, 0);
        issue(1'b0, 32'h28, 32'h0, 4'hF, 6'b0, 32'h00000055, 0);
        issue(1'b1, 32'h28, 32'h99999999, 4'h0, 6'b0, 32'h0, 0);
        issue(1'b0, 32'h28, 32'h0, 4'hF, 6'b0, 32'h00000055, 0);
        // atop ADD without we is a plain read.
        issue(1'b0, 32'h28, 32'h0, 4'hF, 6'b100000, 32'h00000055, 0);
        idle_drain();

        // Reset while a read is in flight drops its response.
        issue(1'b0, 32'h10, 32'h0, 4'hF, 6'b0, 32'hDEADBEEF, 0);
        mem_req = 1'b0;
        rst     = 1'b1;
        exp_q.delete();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("midrst_rvalid", DW'(mem_rvalid_o), 32'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (LAT + 2) @(negedge clk);
        idle_drain();

        // Normal operation resumes after the mid-flight reset.
        issue(1'b0, 32'h14, 32'h0, 4'hF, 6'b0, 32'hA0A0A0A0, 0);
        idle_drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
